// File: rtl/pc_fetch_unit.sv
// Instruction fetch and PC sequencing: fetches the word at PC over a req/ready
// handshake, presents it for one EXEC cycle, then advances PC or halts.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        PCWre,
    input  logic [1:0]  PCSrc,
    input  logic [31:0] Imm,
    input  logic [25:0] JAddr,
    output logic        IMemReq,
    output logic [31:0] IMemAddr,
    input  logic        IMemReady,
    input  logic [31:0] IMemData,
    output logic [31:0] Instr,
    output logic [5:0]  OpCode,
    output logic        InstrValid,
    output logic [31:0] PC,
    output logic [31:0] PC4,
    output logic        Halted
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_FETCH = 2'b01,
        ST_EXEC  = 2'b10,
        ST_HALT  = 2'b11
    } state_t;

    localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

    // Next-PC select; reserved PCSrc encoding falls through to sequential.
    function automatic logic [31:0] next_pc_f(
        input logic [31:0] pc4,
        input logic [1:0]  src,
        input logic [31:0] imm,
        input logic [25:0] jaddr
    );
        logic [31:0] res;
        case (src)
            2'b01:   res = pc4 + {imm[29:0], 2'b00};
            2'b10:   res = {pc4[31:28], jaddr, 2'b00};
            default: res = pc4;
        endcase
        return {res[31:2], 2'b00};
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] pc_r;
    logic [31:0] pc_next_s;
    logic [31:0] pc4_s;
    logic [31:0] instr_r;
    logic [31:0] instr_next_s;
    logic        imem_req_r;
    logic        instr_valid_r;
    logic        halted_r;

    assign pc4_s = pc_r + 32'd4;

    // Next-state, next-PC and instruction-register load decisions.
    always_comb begin
        state_next_s = state_r;
        pc_next_s    = pc_r;
        instr_next_s = instr_r;
        case (state_r)
            ST_IDLE: begin
                state_next_s = ST_FETCH;
            end
            ST_FETCH: begin
                if (IMemReady) begin
                    state_next_s = ST_EXEC;
                    instr_next_s = IMemData;
                end else begin
                    state_next_s = ST_FETCH;
                end
            end
            ST_EXEC: begin
                if (PCWre) begin
                    state_next_s = ST_FETCH;
                    pc_next_s    = next_pc_f(pc4_s, PCSrc, Imm, JAddr);
                end else begin
                    state_next_s = ST_HALT;
                end
            end
            ST_HALT: begin
                state_next_s = ST_HALT;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, PC, instruction register and registered status outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_r       <= ST_IDLE;
            pc_r          <= PC_INIT;
            instr_r       <= 32'h0000_0000;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b0;
            halted_r      <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            pc_r          <= pc_next_s;
            instr_r       <= instr_next_s;
            imem_req_r    <= (state_next_s == ST_FETCH);
            instr_valid_r <= (state_next_s == ST_EXEC);
            halted_r      <= (state_next_s == ST_HALT);
        end
    end

    assign IMemReq    = imem_req_r;
    assign IMemAddr   = pc_r;
    assign Instr      = instr_r;
    assign OpCode     = instr_r[31:26];
    assign InstrValid = instr_valid_r;
    assign PC         = pc_r;
    assign PC4        = pc4_s;
    assign Halted     = halted_r;

endmodule
